// File: rtl/vu_color_rom.sv
// vu_color_rom
// 256 x 24-bit colour lookup for the VU meter display path.
// An 8-bit level/LED index selects an RGB word {R, G, B}. The table
// ramps from green at index 0 through yellow around mid scale to red at
// index 255. Blue is always zero. The output is registered, so a read has
// a latency of one clock. While the read enable is low, the output
// register keeps its value.
// Low half (0x00..0x7F): R rises by 2 per step, G = 0xFF.
// High half (0x80..0xFF): R = 0xFF, G falls by 2 per step to 0x00 at 0xFF.
// Index 0x80 is pinned to pure yellow (FFFF00), so the red ramp starts
// from full yellow. The plain falling ramp would give FFFE00 at this index.

module vu_color_rom (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_addr,
    input  logic        i_ren,
    output logic [23:0] o_data
);

    logic [23:0] w_romWord;
    logic [23:0] r_data;

    // Constant colour table: decode the requested index into its RGB word
    always_comb begin
        w_romWord = 24'h000000;
        case (i_addr)
            8'h00: w_romWord = 24'h00FF00;
            8'h01: w_romWord = 24'h02FF00;
            8'h02: w_romWord = 24'h04FF00;
            8'h03: w_romWord = 24'h06FF00;
            8'h04: w_romWord = 24'h08FF00;
            8'h05: w_romWord = 24'h0AFF00;
            8'h06: w_romWord = 24'h0CFF00;
            8'h07: w_romWord = 24'h0EFF00;
            8'h08: w_romWord = 24'h10FF00;
            8'h09: w_romWord = 24'h12FF00;
            8'h0A: w_romWord = 24'h14FF00;
            8'h0B: w_romWord = 24'h16FF00;
            8'h0C: w_romWord = 24'h18FF00;
            8'h0D: w_romWord = 24'h1AFF00;
            8'h0E: w_romWord = 24'h1CFF00;
            8'h0F: w_romWord = 24'h1EFF00;
            8'h10: w_romWord = 24'h20FF00;
            8'h11: w_romWord = 24'h22FF00;
            8'h12: w_romWord = 24'h24FF00;
            8'h13: w_romWord = 24'h26FF00;
            8'h14: w_romWord = 24'h28FF00;
            8'h15: w_romWord = 24'h2AFF00;
            8'h16: w_romWord = 24'h2CFF00;
            8'h17: w_romWord = 24'h2EFF00;
            8'h18: w_romWord = 24'h30FF00;
            8'h19: w_romWord = 24'h32FF00;
            8'h1A: w_romWord = 24'h34FF00;
            8'h1B: w_romWord = 24'h36FF00;
            8'h1C: w_romWord = 24'h38FF00;
            8'h1D: w_romWord = 24'h3AFF00;
            8'h1E: w_romWord = 24'h3CFF00;
            8'h1F: w_romWord = 24'h3EFF00;
            8'h20: w_romWord = 24'h40FF00;
            8'h21: w_romWord = 24'h42FF00;
            8'h22: w_romWord = 24'h44FF00;
            8'h23: w_romWord = 24'h46FF00;
            8'h24: w_romWord = 24'h48FF00;
            8'h25: w_romWord = 24'h4AFF00;
            8'h26: w_romWord = 24'h4CFF00;
            8'h27: w_romWord = 24'h4EFF00;
            8'h28: w_romWord = 24'h50FF00;
            8'h29: w_romWord = 24'h52FF00;
            8'h2A: w_romWord = 24'h54FF00;
            8'h2B: w_romWord = 24'h56FF00;
            8'h2C: w_romWord = 24'h58FF00;
            8'h2D: w_romWord = 24'h5AFF00;
            8'h2E: w_romWord = 24'h5CFF00;
            8'h2F: w_romWord = 24'h5EFF00;
            8'h30: w_romWord = 24'h60FF00;
            8'h31: w_romWord = 24'h62FF00;
            8'h32: w_romWord = 24'h64FF00;
            8'h33: w_romWord = 24'h66FF00;
            8'h34: w_romWord = 24'h68FF00;
            8'h35: w_romWord = 24'h6AFF00;
            8'h36: w_romWord = 24'h6CFF00;
            8'h37: w_romWord = 24'h6EFF00;
            8'h38: w_romWord = 24'h70FF00;
            8'h39: w_romWord = 24'h72FF00;
            8'h3A: w_romWord = 24'h74FF00;
            8'h3B: w_romWord = 24'h76FF00;
            8'h3C: w_romWord = 24'h78FF00;
            8'h3D: w_romWord = 24'h7AFF00;
            8'h3E: w_romWord = 24'h7CFF00;
            8'h3F: w_romWord = 24'h7EFF00;
            8'h40: w_romWord = 24'h80FF00;
            8'h41: w_romWord = 24'h82FF00;
            8'h42: w_romWord = 24'h84FF00;
            8'h43: w_romWord = 24'h86FF00;
            8'h44: w_romWord = 24'h88FF00;
            8'h45: w_romWord = 24'h8AFF00;
            8'h46: w_romWord = 24'h8CFF00;
            8'h47: w_romWord = 24'h8EFF00;
            8'h48: w_romWord = 24'h90FF00;
            8'h49: w_romWord = 24'h92FF00;
            8'h4A: w_romWord = 24'h94FF00;
            8'h4B: w_romWord = 24'h96FF00;
            8'h4C: w_romWord = 24'h98FF00;
            8'h4D: w_romWord = 24'h9AFF00;
            8'h4E: w_romWord = 24'h9CFF00;
            8'h4F: w_romWord = 24'h9EFF00;
            8'h50: w_romWord = 24'hA0FF00;
            8'h51: w_romWord = 24'hA2FF00;
            8'h52: w_romWord = 24'hA4FF00;
            8'h53: w_romWord = 24'hA6FF00;
            8'h54: w_romWord = 24'hA8FF00;
            8'h55: w_romWord = 24'hAAFF00;
            8'h56: w_romWord = 24'hACFF00;
            8'h57: w_romWord = 24'hAEFF00;
            8'h58: w_romWord = 24'hB0FF00;
            8'h59: w_romWord = 24'hB2FF00;
            8'h5A: w_romWord = 24'hB4FF00;
            8'h5B: w_romWord = 24'hB6FF00;
            8'h5C: w_romWord = 24'hB8FF00;
            8'h5D: w_romWord = 24'hBAFF00;
            8'h5E: w_romWord = 24'hBCFF00;
            8'h5F: w_romWord = 24'hBEFF00;
            8'h60: w_romWord = 24'hC0FF00;
            8'h61: w_romWord = 24'hC2FF00;
            8'h62: w_romWord = 24'hC4FF00;
            8'h63: w_romWord = 24'hC6FF00;
            8'h64: w_romWord = 24'hC8FF00;
            8'h65: w_romWord = 24'hCAFF00;
            8'h66: w_romWord = 24'hCCFF00;
            8'h67: w_romWord = 24'hCEFF00;
            8'h68: w_romWord = 24'hD0FF00;
            8'h69: w_romWord = 24'hD2FF00;
            8'h6A: w_romWord = 24'hD4FF00;
            8'h6B: w_romWord = 24'hD6FF00;
            8'h6C: w_romWord = 24'hD8FF00;
            8'h6D: w_romWord = 24'hDAFF00;
            8'h6E: w_romWord = 24'hDCFF00;
            8'h6F: w_romWord = 24'hDEFF00;
            8'h70: w_romWord = 24'hE0FF00;
            8'h71: w_romWord = 24'hE2FF00;
            8'h72: w_romWord = 24'hE4FF00;
            8'h73: w_romWord = 24'hE6FF00;
            8'h74: w_romWord = 24'hE8FF00;
            8'h75: w_romWord = 24'hEAFF00;
            8'h76: w_romWord = 24'hECFF00;
            8'h77: w_romWord = 24'hEEFF00;
            8'h78: w_romWord = 24'hF0FF00;
            8'h79: w_romWord = 24'hF2FF00;
            8'h7A: w_romWord = 24'hF4FF00;
            8'h7B: w_romWord = 24'hF6FF00;
            8'h7C: w_romWord = 24'hF8FF00;
            8'h7D: w_romWord = 24'hFAFF00;
            8'h7E: w_romWord = 24'hFCFF00;
            8'h7F: w_romWord = 24'hFEFF00;
            8'h80: w_romWord = 24'hFFFF00;
            8'h81: w_romWord = 24'hFFFC00;
            8'h82: w_romWord = 24'hFFFA00;
            8'h83: w_romWord = 24'hFFF800;
            8'h84: w_romWord = 24'hFFF600;
            8'h85: w_romWord = 24'hFFF400;
            8'h86: w_romWord = 24'hFFF200;
            8'h87: w_romWord = 24'hFFF000;
            8'h88: w_romWord = 24'hFFEE00;
            8'h89: w_romWord = 24'hFFEC00;
            8'h8A: w_romWord = 24'hFFEA00;
            8'h8B: w_romWord = 24'hFFE800;
            8'h8C: w_romWord = 24'hFFE600;
            8'h8D: w_romWord = 24'hFFE400;
            8'h8E: w_romWord = 24'hFFE200;
            8'h8F: w_romWord = 24'hFFE000;
            8'h90: w_romWord = 24'hFFDE00;
            8'h91: w_romWord = 24'hFFDC00;
            8'h92: w_romWord = 24'hFFDA00;
            8'h93: w_romWord = 24'hFFD800;
            8'h94: w_romWord = 24'hFFD600;
            8'h95: w_romWord = 24'hFFD400;
            8'h96: w_romWord = 24'hFFD200;
            8'h97: w_romWord = 24'hFFD000;
            8'h98: w_romWord = 24'hFFCE00;
            8'h99: w_romWord = 24'hFFCC00;
            8'h9A: w_romWord = 24'hFFCA00;
            8'h9B: w_romWord = 24'hFFC800;
            8'h9C: w_romWord = 24'hFFC600;
            8'h9D: w_romWord = 24'hFFC400;
            8'h9E: w_romWord = 24'hFFC200;
            8'h9F: w_romWord = 24'hFFC000;
            8'hA0: w_romWord = 24'hFFBE00;
            8'hA1: w_romWord = 24'hFFBC00;
            8'hA2: w_romWord = 24'hFFBA00;
            8'hA3: w_romWord = 24'hFFB800;
            8'hA4: w_romWord = 24'hFFB600;
            8'hA5: w_romWord = 24'hFFB400;
            8'hA6: w_romWord = 24'hFFB200;
            8'hA7: w_romWord = 24'hFFB000;
            8'hA8: w_romWord = 24'hFFAE00;
            8'hA9: w_romWord = 24'hFFAC00;
            8'hAA: w_romWord = 24'hFFAA00;
            8'hAB: w_romWord = 24'hFFA800;
            8'hAC: w_romWord = 24'hFFA600;
            8'hAD: w_romWord = 24'hFFA400;
            8'hAE: w_romWord = 24'hFFA200;
            8'hAF: w_romWord = 24'hFFA000;
            8'hB0: w_romWord = 24'hFF9E00;
            8'hB1: w_romWord = 24'hFF9C00;
            8'hB2: w_romWord = 24'hFF9A00;
            8'hB3: w_romWord = 24'hFF9800;
            8'hB4: w_romWord = 24'hFF9600;
            8'hB5: w_romWord = 24'hFF9400;
            8'hB6: w_romWord = 24'hFF9200;
            8'hB7: w_romWord = 24'hFF9000;
            8'hB8: w_romWord = 24'hFF8E00;
            8'hB9: w_romWord = 24'hFF8C00;
            8'hBA: w_romWord = 24'hFF8A00;
            8'hBB: w_romWord = 24'hFF8800;
            8'hBC: w_romWord = 24'hFF8600;
            8'hBD: w_romWord = 24'hFF8400;
            8'hBE: w_romWord = 24'hFF8200;
            8'hBF: w_romWord = 24'hFF8000;
            8'hC0: w_romWord = 24'hFF7E00;
            8'hC1: w_romWord = 24'hFF7C00;
            8'hC2: w_romWord = 24'hFF7A00;
            8'hC3: w_romWord = 24'hFF7800;
            8'hC4: w_romWord = 24'hFF7600;
            8'hC5: w_romWord = 24'hFF7400;
            8'hC6: w_romWord = 24'hFF7200;
            8'hC7: w_romWord = 24'hFF7000;
            8'hC8: w_romWord = 24'hFF6E00;
            8'hC9: w_romWord = 24'hFF6C00;
            8'hCA: w_romWord = 24'hFF6A00;
            8'hCB: w_romWord = 24'hFF6800;
            8'hCC: w_romWord = 24'hFF6600;
            8'hCD: w_romWord = 24'hFF6400;
            8'hCE: w_romWord = 24'hFF6200;
            8'hCF: w_romWord = 24'hFF6000;
            8'hD0: w_romWord = 24'hFF5E00;
            8'hD1: w_romWord = 24'hFF5C00;
            8'hD2: w_romWord = 24'hFF5A00;
            8'hD3: w_romWord = 24'hFF5800;
            8'hD4: w_romWord = 24'hFF5600;
            8'hD5: w_romWord = 24'hFF5400;
            8'hD6: w_romWord = 24'hFF5200;
            8'hD7: w_romWord = 24'hFF5000;
            8'hD8: w_romWord = 24'hFF4E00;
            8'hD9: w_romWord = 24'hFF4C00;
            8'hDA: w_romWord = 24'hFF4A00;
            8'hDB: w_romWord = 24'hFF4800;
            8'hDC: w_romWord = 24'hFF4600;
            8'hDD: w_romWord = 24'hFF4400;
            8'hDE: w_romWord = 24'hFF4200;
            8'hDF: w_romWord = 24'hFF4000;
            8'hE0: w_romWord = 24'hFF3E00;
            8'hE1: w_romWord = 24'hFF3C00;
            8'hE2: w_romWord = 24'hFF3A00;
            8'hE3: w_romWord = 24'hFF3800;
            8'hE4: w_romWord = 24'hFF3600;
            8'hE5: w_romWord = 24'hFF3400;
            8'hE6: w_romWord = 24'hFF3200;
            8'hE7: w_romWord = 24'hFF3000;
            8'hE8: w_romWord = 24'hFF2E00;
            8'hE9: w_romWord = 24'hFF2C00;
            8'hEA: w_romWord = 24'hFF2A00;
            8'hEB: w_romWord = 24'hFF2800;
            8'hEC: w_romWord = 24'hFF2600;
            8'hED: w_romWord = 24'hFF2400;
            8'hEE: w_romWord = 24'hFF2200;
            8'hEF: w_romWord = 24'hFF2000;
            8'hF0: w_romWord = 24'hFF1E00;
            8'hF1: w_romWord = 24'hFF1C00;
            8'hF2: w_romWord = 24'hFF1A00;
            8'hF3: w_romWord = 24'hFF1800;
            8'hF4: w_romWord = 24'hFF1600;
            8'hF5: w_romWord = 24'hFF1400;
            8'hF6: w_romWord = 24'hFF1200;
            8'hF7: w_romWord = 24'hFF1000;
            8'hF8: w_romWord = 24'hFF0E00;
            8'hF9: w_romWord = 24'hFF0C00;
            8'hFA: w_romWord = 24'hFF0A00;
            8'hFB: w_romWord = 24'hFF0800;
            8'hFC: w_romWord = 24'hFF0600;
            8'hFD: w_romWord = 24'hFF0400;
            8'hFE: w_romWord = 24'hFF0200;
            8'hFF: w_romWord = 24'hFF0000;
            default: w_romWord = 24'h000000;
        endcase
    end

    // Output register: load the looked-up word on enabled reads, hold otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= 24'h000000;
        end else if (i_ren) begin
            r_data <= w_romWord;
        end
    end

    assign o_data = r_data;

endmodule

// File: tb/tb_vu_color_rom.sv
// tb_vu_color_rom
// Directed bench for the VU meter colour ROM. A behavioural model computes
// each table entry arithmetically from its index and tracks the
// one-clock read latency. A compare process checks the DUT against the
// model on every falling edge. Hand-computed literals pin both the DUT
// and the model at the endpoints and at selected points.

module tb_vu_color_rom;

   logic        clock;
   logic        rstN;
   logic [7:0]  addr;
   logic        ren;
   logic [23:0] dataOut;

   logic [23:0] modelData;
   logic        compareEnable;
   int          numCompared;
   int          numMismatched;

   vu_color_rom dut (
      .i_clk   (clock),
      .i_rst_n (rstN),
      .i_addr  (addr),
      .i_ren   (ren),
      .o_data  (dataOut)
   );

   // 10 ns clock; rising edges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Colour for an index straight from the gradient rules
   function automatic logic [23:0] expectedWord(input int a);
      int red;
      int green;
      if (a < 128) begin
         red   = 2 * a;
         green = 255;
      end else if (a == 128) begin
         red   = 255;
         green = 255;
      end else begin
         red   = 255;
         green = 510 - 2 * a;
      end
      return {red[7:0], green[7:0], 8'h00};
   endfunction

   // Record one comparison and report it if it fails
   task automatic recordCompare(input string name, input logic [23:0] actual, input logic [23:0] required);
      numCompared++;
      if (actual !== required) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %06h, expected %06h at %0t", name, actual, required, $time);
      end
   endtask

   // Reference model: registered lookup with asynchronous clear
   always @(posedge clock or negedge rstN) begin
      if (!rstN) begin
         modelData <= 24'h000000;
      end else if (ren) begin
         modelData <= expectedWord(int'(addr));
      end
   end

   // Continuous comparison against the model on each falling edge
   always @(negedge clock) begin
      if (compareEnable) begin
         recordCompare("model", dataOut, modelData);
      end
   end

   // Drive one input pair just after the next rising edge
   task automatic applyStimulus(input logic enable, input logic [7:0] address);
      @(posedge clock);
      #2;
      ren  = enable;
      addr = address;
   endtask

   // Check the DUT output against a hand-computed literal
   task automatic checkOutput(input string name, input logic [23:0] required);
      recordCompare(name, dataOut, required);
   endtask

   // Time-limit guard so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "[TB] time limit expired");
   end

   initial begin
      numCompared   = 0;
      numMismatched = 0;
      compareEnable = 1'b0;
      rstN          = 1'b1;
      ren           = 1'b0;
      addr          = 8'h00;

      // Pin the model at hand-computed points
      recordCompare("modelIdx0",   expectedWord(0),   24'h00FF00);
      recordCompare("modelIdx127", expectedWord(127), 24'hFEFF00);
      recordCompare("modelIdx128", expectedWord(128), 24'hFFFF00);
      recordCompare("modelIdx200", expectedWord(200), 24'hFF6E00);
      recordCompare("modelIdx255", expectedWord(255), 24'hFF0000);

      // Asynchronous reset before any clock edge
      #3;
      rstN = 1'b0;
      #1;
      checkOutput("resetAsync", 24'h000000);
      compareEnable = 1'b1;

      // Reset held with reads requested
      ren  = 1'b1;
      addr = 8'd64;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         checkOutput("resetHeld", 24'h000000);
      end
      #1;
      rstN = 1'b1;
      ren  = 1'b0;

      // Single reads checked one edge later
      applyStimulus(1'b1, 8'd0);
      @(posedge clock); #1; checkOutput("read0", 24'h00FF00);
      applyStimulus(1'b1, 8'd64);
      @(posedge clock); #1; checkOutput("read64", 24'h80FF00);
      applyStimulus(1'b1, 8'd127);
      @(posedge clock); #1; checkOutput("read127", 24'hFEFF00);
      applyStimulus(1'b1, 8'd128);
      @(posedge clock); #1; checkOutput("read128", 24'hFFFF00);
      applyStimulus(1'b1, 8'd200);
      @(posedge clock); #1; checkOutput("read200", 24'hFF6E00);
      applyStimulus(1'b1, 8'd255);
      @(posedge clock); #1; checkOutput("read255", 24'hFF0000);

      // Hold while disabled, then release onto the waiting address
      applyStimulus(1'b1, 8'd10);
      applyStimulus(1'b0, 8'd250);
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         #1;
         checkOutput("hold", 24'h14FF00);
      end
      applyStimulus(1'b1, 8'd250);
      @(posedge clock); #1; checkOutput("holdRelease", 24'hFF0A00);

      // Sweep with one new address every 2.5 clocks, changes away from edges
      @(posedge clock);
      #7;
      for (int i = 0; i < 256; i++) begin
         addr = 8'(i);
         #25;
      end

      // Sweep with one new address per clock, reset pulse in the middle
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, 8'(i));
         if (i == 100) begin
            #1;
            rstN = 1'b0;
            #1;
            checkOutput("resetMidRead", 24'h000000);
            #2;
            rstN = 1'b1;
            @(posedge clock);
            #1;
            checkOutput("recovery", 24'hC8FF00);
         end
      end
      @(posedge clock);
      #1;
      checkOutput("sweepLast", 24'hFF0000);

      ren = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      compareEnable = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
